// File: rtl/pixel_row_output_buffer.sv
// Two-slot ping-pong row buffer. Rows arrive whole on ROW_LOAD and leave as
// BUS_PIXELS-wide beats over a valid/ready bus, in load order.
module pixel_row_output_buffer #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int PIXEL_BITS = 8,
    parameter int BUS_PIXELS = 2
) (
    input  logic                                SYSTEM_CLK,
    input  logic                                RESET,
    input  logic                                ROW_LOAD,
    input  logic [$clog2(HEIGHT):0]             ROW_INDEX,
    input  logic [WIDTH*PIXEL_BITS-1:0]         ROW_DATA,
    output logic                                ROW_READY,
    output logic [BUS_PIXELS*PIXEL_BITS-1:0]    BUS_DATA,
    output logic                                BUS_VALID,
    input  logic                                BUS_READY,
    output logic [$clog2(HEIGHT):0]             BUS_ROW,
    output logic                                BUS_LAST,
    output logic                                FRAME_DONE,
    output logic                                OVERRUN
);

    localparam int BEATS = WIDTH / BUS_PIXELS;
    localparam int IDXW  = $clog2(HEIGHT) + 1;
    localparam int ROWW  = WIDTH * PIXEL_BITS;
    localparam int BUS_W = BUS_PIXELS * PIXEL_BITS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [ROWW-1:0]  r_slot_data [2];
    logic [IDXW-1:0]  r_slot_idx  [2];
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [BW-1:0]    r_beat;
    logic             r_overrun;
    logic             r_frame_done;

    logic             w_ready;
    logic             w_valid;
    logic             w_last_beat;
    logic             w_xfer;
    logic             w_pop;
    logic             w_load_acc;
    logic             w_load_drop;
    logic [BUS_W-1:0] w_bus_data;

    // Handshake decode from registered occupancy; a load is judged against the
    // pre-edge count, so a drop still happens when a pop lands on the same edge.
    always_comb begin
        w_ready     = (r_count != 2'd2);
        w_valid     = (r_count != 2'd0);
        w_last_beat = (r_beat == BW'(BEATS - 1));
        w_xfer      = w_valid && BUS_READY;
        w_pop       = w_xfer && w_last_beat;
        w_load_acc  = ROW_LOAD && w_ready;
        w_load_drop = ROW_LOAD && !w_ready;
    end

    // Select the current beat out of the read slot; zero when nothing is held.
    always_comb begin
        w_bus_data = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (r_beat == BW'(b)) begin
                w_bus_data = r_slot_data[r_rd_ptr][b*BUS_W +: BUS_W];
            end
        end
        if (!w_valid) begin
            w_bus_data = '0;
        end
    end

    // Row storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge SYSTEM_CLK) begin
        if (w_load_acc) begin
            r_slot_data[r_wr_ptr] <= ROW_DATA;
            r_slot_idx[r_wr_ptr]  <= ROW_INDEX;
        end
    end

    // Occupancy, pointers, beat counter and status flags.
    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            r_count      <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_beat       <= '0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case ({w_load_acc, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_load_acc) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_xfer) begin
                if (w_last_beat) begin
                    r_beat   <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end

            if (w_load_drop) begin
                r_overrun <= 1'b1;
            end

            r_frame_done <= w_pop && (r_slot_idx[r_rd_ptr] == IDXW'(HEIGHT - 1));
        end
    end

    assign ROW_READY  = w_ready;
    assign BUS_VALID  = w_valid;
    assign BUS_DATA   = w_bus_data;
    assign BUS_ROW    = w_valid ? r_slot_idx[r_rd_ptr] : '0;
    assign BUS_LAST   = w_valid && w_last_beat;
    assign FRAME_DONE = r_frame_done;
    assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_pixel_row_output_buffer.sv
// Bench for pixel_row_output_buffer: directed scenarios plus random traffic,
// all checked against a queue-of-rows reference model.
module tb_pixel_row_output_buffer;

    localparam int WIDTH      = 4;
    localparam int HEIGHT     = 4;
    localparam int PIXEL_BITS = 8;
    localparam int BUS_PIXELS = 2;
    localparam int BEATS      = WIDTH / BUS_PIXELS;
    localparam int IDXW       = $clog2(HEIGHT) + 1;
    localparam int ROWW       = WIDTH * PIXEL_BITS;
    localparam int BUSW       = BUS_PIXELS * PIXEL_BITS;

    logic            clk = 1'b0;
    logic            rst;
    logic            row_load;
    logic [IDXW-1:0] row_index;
    logic [ROWW-1:0] row_data;
    logic            row_ready;
    logic [BUSW-1:0] bus_data;
    logic            bus_valid;
    logic            bus_ready;
    logic [IDXW-1:0] bus_row;
    logic            bus_last;
    logic            frame_done;
    logic            overrun;

    always #5 clk = ~clk;

    pixel_row_output_buffer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_BITS(PIXEL_BITS), .BUS_PIXELS(BUS_PIXELS)
    ) u_dut (
        .SYSTEM_CLK(clk), .RESET(rst), .ROW_LOAD(row_load), .ROW_INDEX(row_index),
        .ROW_DATA(row_data), .ROW_READY(row_ready), .BUS_DATA(bus_data),
        .BUS_VALID(bus_valid), .BUS_READY(bus_ready), .BUS_ROW(bus_row),
        .BUS_LAST(bus_last), .FRAME_DONE(frame_done), .OVERRUN(overrun)
    );

    // Reference model: rows waiting in load order, beat position in the head row.
    typedef struct {
        logic [IDXW-1:0] idx;
        logic [ROWW-1:0] data;
    } row_t;

    row_t m_q[$];
    int   m_beat;
    bit   m_over;
    bit   m_fd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    task automatic check_outputs();
        logic [ROWW-1:0] sh;
        chk("row_ready", row_ready, m_q.size() != 2);
        chk("bus_valid", bus_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            sh = m_q[0].data >> (m_beat * BUSW);
            chk("bus_data", bus_data, sh[BUSW-1:0]);
            chk("bus_row", bus_row, m_q[0].idx);
            chk("bus_last", bus_last, m_beat == BEATS - 1);
        end else begin
            chk("bus_last_idle", bus_last, 0);
        end
        chk("frame_done", frame_done, m_fd);
        chk("overrun", overrun, m_over);
    endtask

    // One clock: check the state left by the previous edge, then drive the
    // inputs for the coming edge and advance the model past it.
    task automatic step(input bit ld, input logic [IDXW-1:0] idx,
                        input logic [ROWW-1:0] data, input bit rdy);
        bit m_ready, m_valid;
        @(negedge clk);
        check_outputs();
        m_ready = (m_q.size() != 2);
        m_valid = (m_q.size() != 0);
        m_fd = 0;
        if (m_valid && rdy) begin
            if (m_beat == BEATS - 1) begin
                m_fd = (m_q[0].idx == HEIGHT - 1);
                void'(m_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (ld && !m_ready) m_over = 1;
        if (ld && m_ready) m_q.push_back('{idx: idx, data: data});
        row_load  = ld;
        row_index = idx;
        row_data  = data;
        bus_ready = rdy;
    endtask

    // Asynchronous reset with a load held high that must be ignored.
    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        rst       = 1'b1;
        row_load  = 1'b1;
        row_index = 1;
        row_data  = 32'hDEADBEEF;
        bus_ready = 1'b1;
        #1;
        chk("rst_valid", bus_valid, 0);
        chk("rst_last", bus_last, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_data", bus_data, 0);
        chk("rst_row", bus_row, 0);
        chk("rst_ready", row_ready, 1);
        chk("rst_over", overrun, 0);
        m_q.delete();
        m_beat = 0;
        m_over = 0;
        m_fd   = 0;
        @(negedge clk);
        rst      = 1'b0;
        row_load = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, '0, rdy);
    endtask

    initial begin
        rst = 1'b1; row_load = 1'b0; row_index = '0; row_data = '0; bus_ready = 1'b0;
        m_beat = 0; m_over = 0; m_fd = 0;
        #12;
        do_reset();

        // Single row, two beats.
        step(1, 0, 32'h44332211, 1);
        #6;
        chk("dir_beat0", bus_data, 16'h2211);
        chk("dir_row0", bus_row, 0);
        chk("dir_last0", bus_last, 0);
        step(0, 0, 0, 1);
        #6;
        chk("dir_beat1", bus_data, 16'h4433);
        chk("dir_last1", bus_last, 1);
        idle(2, 1);

        // Full frame back-to-back, loading whenever there is room.
        do_reset();
        begin
            int next_row = 0;
            for (int c = 0; c < 14; c++) begin
                if (next_row < HEIGHT && m_q.size() != 2) begin
                    step(1, IDXW'(next_row), {$urandom}, 1);
                    next_row++;
                end else begin
                    step(0, 0, 0, 1);
                end
            end
        end

        // Stall with both slots full, third load dropped.
        do_reset();
        step(1, 0, 32'hA1A2A3A4, 0);
        step(1, 1, 32'hB1B2B3B4, 0);
        step(1, 2, 32'hC1C2C3C4, 0);
        idle(3, 0);
        idle(5, 1);

        // Third load coinciding with the final-beat pop is still dropped.
        do_reset();
        step(1, 0, 32'h01020304, 0);
        step(1, 1, 32'h05060708, 0);
        step(0, 0, 0, 1);
        step(1, 2, 32'h090A0B0C, 1);
        idle(4, 1);

        // Ready toggling every cycle.
        do_reset();
        step(1, 0, 32'h10203040, 1);
        step(1, 1, 32'h50607080, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, i[0]);

        // Reset after the first beat of a row.
        do_reset();
        step(1, 0, 32'h44332211, 1);
        step(0, 0, 0, 1);
        do_reset();
        step(1, 2, 32'h88776655, 1);
        idle(3, 1);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 1) == 1, IDXW'($urandom_range(0, (1 << IDXW) - 1)),
                 {$urandom}, $urandom_range(0, 9) < 7);
        end
        step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
